// File: rtl/reg_master.sv
// Command parser and strobe sequencer for the byte-addressed register slave.
// Turns UART command bytes into slave read/write sequences and returns one response byte per command.
module reg_master #(
  parameter int unsigned NUM_REGS     = 15,
  parameter logic [7:0]  ACK          = 8'h06,
  parameter logic [7:0]  NAK          = 8'h15,
  parameter int unsigned RD_TIMEOUT   = 8,
  parameter int unsigned BYTE_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic [7:0] reg_data,
  output logic       reg_read,
  output logic       reg_write,
  input  logic [7:0] reg_rdata,
  input  logic       reg_valid,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE, RD_ADDR, RD_WAIT, RD_REL, WR_WAIT, WR_ADDR, WR_DATA, WR_COMMIT, RESP, GAP
  } state_t;

  localparam logic [15:0] RD_LAST   = 16'(RD_TIMEOUT - 1);
  localparam logic [15:0] BYTE_LAST = 16'(BYTE_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [15:0] timer;
  logic        cmd_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cmd_ok = (rx_data[6:4] == 3'b000) && ({4'b0000, rx_data[3:0]} < 8'(NUM_REGS));

  // Outputs are registered on state entry, so each strobe is visible during the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= 4'd0;
      wdata     <= 8'd0;
      timer     <= 16'd0;
      tx_data   <= 8'd0;
      tx_send   <= 1'b0;
      reg_data  <= 8'd0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            timer <= 16'd0;
            addr  <= rx_data[3:0];
            if (!cmd_ok) begin
              err     <= 1'b1;
              tx_data <= NAK;
              tx_send <= !tx_busy;
              state   <= RESP;
            end else if (rx_data[7]) begin
              state <= WR_WAIT;
            end else begin
              reg_data <= {4'b0000, rx_data[3:0]};
              reg_read <= 1'b1;
              state    <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          timer <= 16'd0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Data beats the timeout when both land in the same cycle.
          if (reg_valid) begin
            tx_data  <= reg_rdata;
            reg_read <= 1'b0;
            state    <= RD_REL;
          end else if (timer == RD_LAST) begin
            tx_data  <= NAK;
            reg_read <= 1'b0;
            state    <= RD_REL;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        RD_REL: begin
          tx_send <= !tx_busy;
          state   <= RESP;
        end
        WR_WAIT: begin
          if (rx_valid) begin
            wdata     <= rx_data;
            reg_data  <= {4'b0000, addr};
            reg_write <= 1'b1;
            state     <= WR_ADDR;
          end else if (timer == BYTE_LAST) begin
            err     <= 1'b1;
            tx_data <= NAK;
            tx_send <= !tx_busy;
            state   <= RESP;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        WR_ADDR: begin
          reg_data <= wdata;
          state    <= WR_DATA;
        end
        WR_DATA: begin
          reg_write <= 1'b0;
          state     <= WR_COMMIT;
        end
        WR_COMMIT: begin
          tx_data <= ACK;
          tx_send <= !tx_busy;
          state   <= RESP;
        end
        RESP: begin
          // tx_send may already be up from the entry look-ahead; otherwise fire once the TX frees up.
          if (tx_send) begin
            tx_send <= 1'b0;
            state   <= GAP;
          end else if (!tx_busy) begin
            tx_send <= 1'b1;
          end else begin
            tx_send <= 1'b0;
          end
        end
        GAP: begin
          timer <= 16'd0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (rx_valid && (state != IDLE) && (state != WR_WAIT)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_master.sv
// Self-checking bench for reg_master: behavioural register slave, response scoreboard and
// per-cycle history of the DUT outputs for latency checks.
module tb_reg_master;

  localparam int NUM = 15;
  localparam int RT  = 8;
  localparam int BT  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy = 1'b0;
  logic [7:0] reg_data;
  logic       reg_read;
  logic       reg_write;
  logic [7:0] reg_rdata;
  logic       reg_valid;
  logic       err;

  reg_master #(.NUM_REGS(NUM), .RD_TIMEOUT(RT), .BYTE_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .reg_data(reg_data), .reg_read(reg_read), .reg_write(reg_write),
    .reg_rdata(reg_rdata), .reg_valid(reg_valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave: address on first write cycle, data captured when write falls.
  logic [7:0] mem [16];
  logic [3:0] waddr;
  logic       prev_w;
  int         s_cnt;
  logic       mute = 1'b0;
  localparam int LAT = 1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_valid <= 1'b0;
      reg_rdata <= 8'd0;
      s_cnt     <= 0;
      prev_w    <= 1'b0;
      waddr     <= 4'd0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
      mem[3] <= 8'hA5;
    end else begin
      prev_w <= reg_write;
      if (reg_write && !prev_w) waddr <= reg_data[3:0];
      if (!reg_write && prev_w && (waddr < 4'(NUM))) mem[waddr] <= reg_data;
      if (reg_read) begin
        if (!mute && (reg_data < 8'(NUM))) begin
          if (s_cnt == LAT) begin
            reg_valid <= 1'b1;
            reg_rdata <= mem[reg_data[3:0]];
          end else begin
            s_cnt <= s_cnt + 1;
          end
        end
      end else begin
        reg_valid <= 1'b0;
        s_cnt     <= 0;
      end
    end
  end

  // Monitor: scoreboard pop on tx_send, event counters and a 64-cycle history.
  logic [7:0] sb [$];
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, tx_cnt = 0, both_cnt = 0;
  int last_tx_cyc = 0, rd_fall_cyc = 0;
  logic prev_rd = 1'b0;
  logic hr [64];
  logic hw [64];
  logic he [64];
  logic ht [64];
  logic [7:0] hd [64];
  always @(negedge clk) begin
    hr[cyc % 64] = reg_read;
    hw[cyc % 64] = reg_write;
    he[cyc % 64] = err;
    ht[cyc % 64] = tx_send;
    hd[cyc % 64] = reg_data;
    if (reg_read) rd_cnt++;
    if (reg_write) wr_cnt++;
    if (err) err_cnt++;
    if (reg_read && reg_write) both_cnt++;
    if (!reg_read && prev_rd) rd_fall_cyc = cyc;
    prev_rd = reg_read;
    if (tx_send) begin
      tx_cnt++;
      last_tx_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx got %02h expected none", tx_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (tx_data !== exp) begin
          errors++;
          $display("FAIL tx_data got %02h expected %02h", tx_data, exp);
        end
      end
    end
  end

  int rx_cyc;
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_cyc   = cyc;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout pending %0d expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [19:0] got;
    got = {tx_data, tx_send, reg_data, reg_read, reg_write, err};
    checks++;
    if (got !== 20'd0) begin
      errors++;
      $display("FAIL %s outputs got %05h expected 00000", tag, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    int c;
    sb.push_back(8'hA5);
    send_byte(8'h03);
    c = rx_cyc;
    wait_done(40);
    checks++;
    if (hr[(c + 1) % 64] !== 1'b1 || hd[(c + 1) % 64] !== 8'h03) begin
      errors++;
      $display("FAIL read_rise read=%b data=%02h expected 1/03", hr[(c + 1) % 64], hd[(c + 1) % 64]);
    end
    checks++;
    if (hr[c % 64] !== 1'b0) begin
      errors++;
      $display("FAIL read_early read=%b expected 0", hr[c % 64]);
    end
    checks++;
    if (last_tx_cyc != rd_fall_cyc + 1) begin
      errors++;
      $display("FAIL read_tx_latency got %0d expected %0d", last_tx_cyc, rd_fall_cyc + 1);
    end
  endtask

  task automatic test_write();
    int d;
    sb.push_back(8'h06);
    send_byte(8'h87);
    send_byte(8'h3C);
    d = rx_cyc;
    wait_done(40);
    checks++;
    if ({hw[(d + 1) % 64], hw[(d + 2) % 64], hw[(d + 3) % 64]} !== 3'b110) begin
      errors++;
      $display("FAIL write_strobes got %b%b%b expected 110", hw[(d + 1) % 64], hw[(d + 2) % 64], hw[(d + 3) % 64]);
    end
    checks++;
    if (hd[(d + 1) % 64] !== 8'h07 || hd[(d + 2) % 64] !== 8'h3C || hd[(d + 3) % 64] !== 8'h3C) begin
      errors++;
      $display("FAIL write_data got %02h %02h %02h expected 07 3C 3C", hd[(d + 1) % 64], hd[(d + 2) % 64], hd[(d + 3) % 64]);
    end
    checks++;
    if (last_tx_cyc != d + 4) begin
      errors++;
      $display("FAIL write_tx_latency got %0d expected %0d", last_tx_cyc, d + 4);
    end
    sb.push_back(8'h3C);
    send_byte(8'h07);
    wait_done(40);
  endtask

  task automatic test_reject(input logic [7:0] cmd);
    int e0, r0, w0, c;
    e0 = err_cnt; r0 = rd_cnt; w0 = wr_cnt;
    sb.push_back(8'h15);
    send_byte(cmd);
    c = rx_cyc;
    wait_done(40);
    checks++;
    if (err_cnt - e0 != 1 || he[(c + 1) % 64] !== 1'b1) begin
      errors++;
      $display("FAIL reject_err cmd %02h pulses %0d expected 1", cmd, err_cnt - e0);
    end
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL reject_touch cmd %02h rd %0d wr %0d expected 0 0", cmd, rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_byte_timeout();
    int e0, w0, c;
    e0 = err_cnt; w0 = wr_cnt;
    sb.push_back(8'h15);
    send_byte(8'h85);
    c = rx_cyc;
    wait_done(BT + 50);
    checks++;
    if (err_cnt - e0 != 1 || wr_cnt != w0) begin
      errors++;
      $display("FAIL byte_timeout err %0d wr %0d expected 1 0", err_cnt - e0, wr_cnt - w0);
    end
    checks++;
    if (last_tx_cyc != c + BT + 1) begin
      errors++;
      $display("FAIL byte_timeout_latency got %0d expected %0d", last_tx_cyc, c + BT + 1);
    end
    // Data byte landing on the final wait cycle must still be taken as data.
    e0 = err_cnt;
    sb.push_back(8'h06);
    send_byte(8'h85);
    c = rx_cyc;
    repeat (BT - 2) @(posedge clk);
    send_byte(8'h5A);
    wait_done(40);
    checks++;
    if (hw[(c + BT + 1) % 64] !== 1'b1 || err_cnt != e0 || mem[5] !== 8'h5A) begin
      errors++;
      $display("FAIL byte_edge write=%b err %0d mem5 %02h expected 1 0 5A", hw[(c + BT + 1) % 64], err_cnt - e0, mem[5]);
    end
  endtask

  task automatic test_rd_timeout_backpressure();
    int r0, t0, f;
    mute = 1'b1;
    r0 = rd_cnt;
    sb.push_back(8'h15);
    send_byte(8'h02);
    wait_done(40);
    mute = 1'b0;
    checks++;
    if (rd_cnt - r0 < RT || rd_cnt - r0 > RT + 1) begin
      errors++;
      $display("FAIL rd_timeout_len got %0d expected %0d..%0d", rd_cnt - r0, RT, RT + 1);
    end
    checks++;
    if (last_tx_cyc != rd_fall_cyc + 1) begin
      errors++;
      $display("FAIL rd_timeout_tx got %0d expected %0d", last_tx_cyc, rd_fall_cyc + 1);
    end
    tx_busy = 1'b1;
    t0 = tx_cnt;
    sb.push_back(8'hA5);
    send_byte(8'h03);
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (tx_cnt != t0) begin
      errors++;
      $display("FAIL busy_hold sends %0d expected 0", tx_cnt - t0);
    end
    tx_busy = 1'b0;
    f = cyc;
    wait_done(20);
    checks++;
    if (ht[(f + 1) % 64] !== 1'b1 || ht[f % 64] !== 1'b0) begin
      errors++;
      $display("FAIL busy_release send@f=%b send@f+1=%b expected 0 1", ht[f % 64], ht[(f + 1) % 64]);
    end
  endtask

  task automatic test_overrun_reset();
    int e0, c;
    e0 = err_cnt;
    sb.push_back(8'hA5);
    send_byte(8'h03);
    send_byte(8'h55);
    c = rx_cyc;
    wait_done(40);
    checks++;
    if (err_cnt - e0 != 1 || he[(c + 1) % 64] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_err pulses %0d expected 1", err_cnt - e0);
    end
    send_byte(8'h87);
    send_byte(8'h99);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_write_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    sb.push_back(8'h77);
    send_byte(8'h07);
    wait_done(40);
    sb.push_back(8'h06);
    send_byte(8'h8A);
    send_byte(8'hC3);
    wait_done(40);
    sb.push_back(8'hC3);
    send_byte(8'h0A);
    wait_done(40);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_reject(8'h0F);
    test_reject(8'h23);
    test_byte_timeout();
    test_rd_timeout_backpressure();
    test_overrun_reset();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL read_write_overlap cycles %0d expected 0", both_cnt);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_responses %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_master.md
Name: reg_master

Overview:
- Host-side initiator for the byte-addressed register slave.
- Parses command bytes arriving from the UART receiver and drives the slave's read/write/data strobes with the exact sequencing that slave requires.
- Returns one response byte per command to the UART transmitter: read data, ACK or NAK.
- Sits between the UART RX/TX pair and the register slave.

Parameters:
- NUM_REGS, 15: number of valid addresses (0..NUM_REGS-1); the slave ignores addresses >= NUM_REGS.
- ACK, 8'h06: response byte for a completed write.
- NAK, 8'h15: response byte for a rejected or timed-out command.
- RD_TIMEOUT, 8: cycles to wait for reg_valid after read is asserted.
- BYTE_TIMEOUT, 50000: cycles to wait for a write's data byte.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- rx_data, input, 8: byte from UART receiver.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid this cycle.
- tx_data, output, 8: response byte to UART transmitter.
- tx_send, output, 1: one-cycle strobe to start transmission.
- tx_busy, input, 1: transmitter is busy; tx_send must not be pulsed while high.
- reg_data, output, 8: drives the slave's data_in (address or write data).
- reg_read, output, 1: slave read strobe.
- reg_write, output, 1: slave write strobe.
- reg_rdata, input, 8: slave data_out.
- reg_valid, input, 1: slave valid.
- err, output, 1: one-cycle pulse on a dropped or malformed byte.

Behaviour:
- Reset: state IDLE; tx_data, tx_send, reg_data, reg_read, reg_write, err = 0; timers cleared. The slave shares rst, so a reset mid-operation leaves both ends idle and the in-flight command is lost with no response.
- Command byte format:
  - bit7 = 1 write, 0 read.
  - bits6:4 must be 0.
  - bits3:0 = address.
  - Malformed (bits6:4 != 0) or address >= NUM_REGS: NAK, err pulse, slave never touched.
- reg_read and reg_write are never high in the same cycle.
- States and transitions:
  - IDLE: on rx_valid, decode. Valid read -> RD_ADDR. Valid write -> WR_WAIT. Bad -> RESP with NAK.
  - RD_ADDR: reg_data = addr, reg_read = 1; -> RD_WAIT.
  - RD_WAIT: hold reg_data and reg_read.
    - reg_valid = 1: latch reg_rdata as response; -> RD_REL.
    - RD_TIMEOUT cycles elapse: response NAK; -> RD_REL.
  - RD_REL: reg_read = 0 for exactly one cycle (slave returns to its address state and clears valid); -> RESP.
  - WR_WAIT: wait for the data byte.
    - rx_valid: latch wdata; -> WR_ADDR.
    - BYTE_TIMEOUT cycles elapse: NAK, err pulse; -> RESP.
  - WR_ADDR: reg_data = addr, reg_write = 1 for one cycle; -> WR_DATA.
  - WR_DATA: reg_data = wdata, reg_write = 1 for one cycle; -> WR_COMMIT.
  - WR_COMMIT: reg_data = wdata, reg_write = 0 for one cycle. The slave captures wdata on this edge. Response ACK; -> RESP.
  - RESP: wait for tx_busy = 0. Then tx_data = response and tx_send = 1 for one cycle; -> GAP.
  - GAP: one idle cycle with all strobes low; -> IDLE.
- Latencies:
  - Read: reg_read rises 1 cycle after the command's rx_valid.
  - Write: reg_write rises 1 cycle after the data byte's rx_valid; the write completes 3 cycles later.
  - With tx_busy = 0, tx_send follows RD_REL or WR_COMMIT by 1 cycle.
- rx_valid in any state other than IDLE or WR_WAIT: byte discarded, err pulses for 1 cycle, state unaffected.
- rx_valid and a timeout expiring in the same WR_WAIT cycle: the byte wins and the write proceeds.
- reg_valid arriving in the same cycle the timeout expires: data wins.
- Outside the active states, reg_data holds its last value.
- Timer counters: 16 bits, saturating, cleared on every state entry.

Test Plan:
- Read of a register pre-loaded with 0xA5 at addr 3: rx 0x03 -> reg_read high with reg_data = 0x03; then reg_read low for one cycle; tx_send with tx_data = 0xA5.
- Write of 0x3C to addr 7: rx 0x87 then 0x3C -> reg_write sequence 1,1,0 with reg_data 0x07, 0x3C, 0x3C; tx_data = 0x06. A follow-up read of 0x07 returns 0x3C.
- Rejected commands: rx 0x0F (addr 15) -> tx_data = 0x15, err pulse, reg_read/reg_write never asserted. Same response for rx 0x23.
- Write byte timeout: rx 0x85 then no byte for 50000 cycles -> NAK, err pulse, reg_write never asserted. A byte arriving exactly on the expiry cycle is accepted as data.
- Read timeout and TX back-pressure: reg_valid held 0 -> after 8 cycles reg_read drops and NAK is sent. With tx_busy held high for 100 cycles, tx_send waits and fires the cycle after tx_busy falls.
- Overrun and reset: rx_valid during RD_WAIT -> err pulse, read result unaffected. Assert rst during WR_DATA -> all outputs 0 immediately; the next command behaves normally.
